// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, 32 iterations plus one sign-fix cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(31);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand sign handling on the input side (used only at acceptance)
  logic            a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf, fast_path;
  logic [XLEN-1:0] fast_res;

  assign a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed & operand_a[XLEN-1];
  assign b_neg    = b_signed & operand_b[XLEN-1];
  assign a_mag    = a_neg ? XLEN'(-operand_a) : operand_a;
  assign b_mag    = b_neg ? XLEN'(-operand_b) : operand_b;

  // Division: op[0]=1 is unsigned, op[1]=1 selects the remainder
  assign neg_in = op[2] ? (op[0] ? 1'b0 : (op[1] ? a_neg : (a_neg ^ b_neg)))
                        : (a_neg ^ b_neg);

  assign div_by_zero = op[2] && (operand_b == '0);
  assign div_ovf     = op[2] && !op[0] && (operand_a == INT_MIN) && (operand_b == ALL_ONE);
  assign fast_path   = div_by_zero || div_ovf;
  assign fast_res    = div_by_zero ? (op[1] ? operand_a : ALL_ONE)
                                   : (op[1] ? '0 : INT_MIN);

  // One shift-add step: acc = {partial_sum, remaining_multiplier}
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step: acc = {partial_remainder, dividend/quotient bits}
  logic [XLEN:0]   div_rem_sh;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;
  logic [PW-1:0]   div_next;
  logic            unused_div_msb;

  assign div_rem_sh     = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
  assign div_diff       = {1'b0, div_rem_sh} - {2'b00, b_q};
  assign div_ge         = ~div_diff[XLEN+1];
  assign div_next       = {(div_ge ? div_diff[XLEN-1:0] : div_rem_sh[XLEN-1:0]),
                           acc_q[XLEN-2:0], div_ge};
  assign unused_div_msb = div_diff[XLEN];

  // Sign correction and result selection
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, fix_res;

  assign prod_fix = neg_q ? PW'(-acc_q) : acc_q;
  assign div_sel  = op_q[1] ? acc_q[PW-1:XLEN] : acc_q[XLEN-1:0];
  assign div_fix  = neg_q ? XLEN'(-div_sel) : div_sel;
  assign fix_res  = op_q[2] ? div_fix
                  : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN]);

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d  = op;
            neg_d = neg_in;
            b_d   = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            cnt_d = '0;
            if (fast_path) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, fast paths,
// flush, ignored start, back-to-back throughput and reset behaviour.
module tb_muldiv_seq;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Launch one op from a negedge with the DUT idle; observe 60 cycles after acceptance
  task automatic run_op(input logic [2:0] o, input logic [31:0] oa, input logic [31:0] ob,
                        output int lat, output int busy_cyc, output int extra_done,
                        output logic [31:0] res);
    op = o; operand_a = oa; operand_b = ob; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_REMU; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0BAD_F00D;
    lat = 999; busy_cyc = 0; extra_done = 0; res = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        if (lat == 999) begin
          lat = c;
          res = result;
        end else begin
          extra_done++;
        end
      end
    end
  endtask

  task automatic test_reset();
    int lat, bc, xd;
    logic [31:0] res;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
    start = 1'b1; operand_a = 32'd1; operand_b = 32'd1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_over_start busy got %b exp 0", busy); end
    rst = 1'b0;
    run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, lat, bc, xd, res);
    checks++; if (lat !== 34) begin errors++; $display("FAIL first_mul_latency got %0d exp 34", lat); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL first_mul_result got %h exp ffffffeb", res); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL first_mul_busy_cycles got %0d exp 33", bc); end
    checks++; if (xd !== 0) begin errors++; $display("FAIL first_mul_extra_done got %0d exp 0", xd); end
  endtask

  task automatic test_mul();
    vec_t v [0:4];
    int lat, bc, xd;
    logic [31:0] res;
    v[0] = {OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[1] = {OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    v[2] = {OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    v[3] = {OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    v[4] = {OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, bc, xd, res);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL mul_result[%0d] got %h exp %h", i, res, v[i].exp); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp 34", i, lat); end
      checks++; if (xd !== 0) begin errors++; $display("FAIL mul_extra_done[%0d] got %0d exp 0", i, xd); end
    end
  endtask

  task automatic test_div();
    vec_t v [0:5];
    int lat, bc, xd;
    logic [31:0] res;
    v[0] = {OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    v[1] = {OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    v[2] = {OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
    v[3] = {OP_REMU, 32'd100,       32'd7,         32'd2};
    v[4] = {OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    v[5] = {OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, bc, xd, res);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL div_result[%0d] got %h exp %h", i, res, v[i].exp); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency[%0d] got %0d exp 34", i, lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL div_busy_cycles[%0d] got %0d exp 33", i, bc); end
    end
  endtask

  task automatic test_fast();
    vec_t v [0:4];
    int lat, bc, xd;
    logic [31:0] res;
    v[0] = {OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[1] = {OP_REM,  32'd5,         32'd0,         32'h0000_0005};
    v[2] = {OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[3] = {OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    v[4] = {OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, bc, xd, res);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL fast_result[%0d] got %h exp %h", i, res, v[i].exp); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL fast_latency[%0d] got %0d exp 1", i, lat); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL fast_busy_cycles[%0d] got %0d exp 0", i, bc); end
    end
  endtask

  // Previous result is 0xFFFFFFFF from the last fast-path op
  task automatic test_flush();
    int lat, bc, xd, seen_done;
    logic [31:0] res;
    op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %b exp 0", busy); end
    checks++; if (done !== 1'b0 || seen_done !== 0) begin errors++; $display("FAIL flush_done got %b/%0d exp 0/0", done, seen_done); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_result_hold got %h exp ffffffff", result); end
    run_op(OP_DIV, 32'd100, 32'd7, lat, bc, xd, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL post_flush_result got %h exp 0000000e", res); end
    checks++; if (lat !== 34 || xd !== 0) begin errors++; $display("FAIL post_flush_timing got lat %0d extra %0d exp 34/0", lat, xd); end
  endtask

  task automatic test_ignored_start();
    int lat, ndone, bc;
    logic [31:0] res;
    op = OP_MUL; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 999; ndone = 0; bc = 0; res = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin ndone++; if (lat == 999) begin lat = c; res = result; end end
      if (c == 5 || c == 34) begin
        start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL ignored_start_result got %h exp 0000002a", res); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignored_start_done_count got %0d exp 1", ndone); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignored_start_latency got %0d exp 34", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL ignored_start_busy_cycles got %0d exp 33", bc); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [31:0] r1;
    op = OP_MUL; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; r1 = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done && d2 == 0) begin
        if (d1 == 0) begin d1 = c; r1 = result; end
        else begin d2 = c; start = 1'b0; end
      end
    end
    start = 1'b0;
    checks++; if (d1 !== 34) begin errors++; $display("FAIL b2b_first_done got %0d exp 34", d1); end
    checks++; if (d2 - d1 !== 35) begin errors++; $display("FAIL b2b_spacing got %0d exp 35", d2 - d1); end
    checks++; if (r1 !== 32'd15) begin errors++; $display("FAIL b2b_result got %h exp 0000000f", r1); end
  endtask

  task automatic test_rst_fix();
    int ndone;
    op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (33) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_fix_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_fix_done got %b exp 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_fix_result got %h exp 00000000", result); end
    ndone = 0;
    repeat (5) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_fix_late_done got %0d exp 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_flush();
    test_ignored_start();
    test_back_to_back();
    test_rst_fix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
